// File: rtl/gelato_types_pkg.sv
// Shared types for the gelato L2 request path: requester count and arbiter states.
package gelato_types;

  localparam int NUM_L2_REQ = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } l2_arb_state_t;

endpackage

// File: rtl/gelato_rr_picker.sv
// Rotating-priority search: first set bit of valid at or after ptr, wrapping modulo N.
module gelato_rr_picker #(
  parameter int N  = 5,
  parameter int PW = 3
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  output logic          found,
  output logic [PW-1:0] idx
);

  logic [PW:0] cand;

  // Walk offsets from farthest to nearest so the nearest valid index wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = {1'b0, ptr} + (PW+1)'(i);
      if (cand >= (PW+1)'(N)) cand = cand - (PW+1)'(N);
      if (valid[cand[PW-1:0]]) begin
        found = 1'b1;
        idx   = cand[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/gelato_l2_request_arbiter.sv
// Round-robin arbiter sharing one L2 port among NUM_REQ L1 requesters, one request in flight.
module gelato_l2_request_arbiter
  import gelato_types::*;
#(
  parameter int NUM_REQ    = NUM_L2_REQ,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 rdy,
  input  logic [NUM_REQ-1:0]                   req_valid,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr,
  output logic [NUM_REQ-1:0]                   req_done,
  output logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_data,
  output logic                                 l2_valid,
  output logic [ADDR_WIDTH-1:0]                l2_addr,
  input  logic                                 l2_done,
  input  logic [DATA_WIDTH-1:0]                l2_data
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  l2_arb_state_t state;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] grant;
  logic          pick_found;
  logic [PW-1:0] pick_idx;

  gelato_rr_picker #(.N(NUM_REQ), .PW(PW)) u_picker (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant    <= '0;
      l2_valid <= 1'b0;
      l2_addr  <= '0;
      req_done <= '0;
      req_data <= '0;
    end else if (rdy) begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant    <= pick_idx;
            l2_valid <= 1'b1;
            l2_addr  <= req_addr[pick_idx];
            state    <= BUSY;
          end
        end
        // Requester inputs are ignored here; the latched grant owns the L2 until it answers.
        BUSY: begin
          if (l2_done) begin
            l2_valid        <= 1'b0;
            req_done[grant] <= 1'b1;
            req_data[grant] <= l2_data;
            rr_ptr          <= (grant == PW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
            state           <= RESP;
          end
        end
        RESP: begin
          req_done <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gelato_l2_request_arbiter.sv
// Scoreboard bench: transaction-level model pushes expected grants/completions, monitor pops and compares.
module tb_gelato_l2_request_arbiter;

  localparam int N  = 5;
  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct {
    int          idx;
    logic [31:0] val;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst_n, rdy, l2_done;
  logic [N-1:0]         req_valid, req_done;
  logic [N-1:0][AW-1:0] req_addr;
  logic [N-1:0][DW-1:0] req_data;
  logic                 l2_valid;
  logic [AW-1:0]        l2_addr;
  logic [DW-1:0]        l2_data;

  int   tests = 0, fails = 0;
  exp_t grant_q[$];
  exp_t done_q[$];
  int   grant_log[$];
  bit   exp_lv = 1'b0;

  bit          l2_auto = 1'b1, l2_rand = 1'b0, req_auto = 1'b0, rearm = 1'b0;
  bit          rdy_auto = 1'b0, rst_auto = 1'b0;
  int          l2_lat = 1, l2_cnt = 0;
  logic [31:0] l2_fix = 32'hDEADBEEF;

  always #5 clk = ~clk;

  gelato_l2_request_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rdy       (rdy),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_done  (req_done),
    .req_data  (req_data),
    .l2_valid  (l2_valid),
    .l2_addr   (l2_addr),
    .l2_done   (l2_done),
    .l2_data   (l2_data)
  );

  task automatic chk(input bit ok, input string nm, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: one transaction at a time, round-robin from the slot after the last served.
  initial begin
    int   owner, ptr, j;
    bit   cool;
    exp_t it;
    owner = -1; ptr = 0; cool = 1'b0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        owner = -1; ptr = 0; cool = 1'b0; exp_lv = 1'b0;
        grant_q.delete(); done_q.delete();
      end else if (rdy) begin
        if (cool) cool = 1'b0;
        else if (owner < 0) begin
          for (int k = 0; k < N; k++) begin
            j = (ptr + k) % N;
            if (owner < 0 && req_valid[j]) owner = j;
          end
          if (owner >= 0) begin
            it.idx = owner; it.val = req_addr[owner];
            grant_q.push_back(it);
            exp_lv = 1'b1;
          end
        end else if (l2_done) begin
          it.idx = owner; it.val = l2_data;
          done_q.push_back(it);
          ptr = (owner + 1) % N;
          owner = -1; cool = 1'b1; exp_lv = 1'b0;
        end
      end
    end
  end

  // Monitor: compares DUT outputs 1ns after every rising edge.
  initial begin
    logic [N-1:0][DW-1:0] exp_data, p_data;
    logic                 p_lv;
    logic [AW-1:0]        p_la;
    logic [N-1:0]         p_done, oh;
    bit                   r, e;
    exp_t                 g, d;
    exp_data = '0; p_data = '0; p_lv = 1'b0; p_la = '0; p_done = '0;
    forever begin
      @(posedge clk);
      r = rst_n; e = rdy;
      #1;
      if (!r) begin
        exp_data = '0;
        chk(l2_valid === 1'b0 && l2_addr === '0 && req_done === '0 && req_data === '0,
            "reset_outputs", {l2_valid, req_done, l2_addr}, '0);
      end else if (!e) begin
        chk(l2_valid === p_lv && l2_addr === p_la && req_done === p_done && req_data === p_data,
            "rdy_hold", {l2_valid, req_done, l2_addr}, {p_lv, p_done, p_la});
      end else begin
        if (grant_q.size() > 0) begin
          g = grant_q.pop_front();
          chk(l2_valid === 1'b1 && l2_addr === g.val, "grant_addr", {l2_valid, l2_addr}, {1'b1, g.val});
          grant_log.push_back(int'(l2_addr[3:0]));
        end else
          chk(l2_addr === p_la, "l2_addr_hold", l2_addr, p_la);
        chk(l2_valid === exp_lv, "l2_valid", l2_valid, exp_lv);
        if (done_q.size() > 0) begin
          d = done_q.pop_front();
          exp_data[d.idx] = d.val;
          oh = '0; oh[d.idx] = 1'b1;
          chk(req_done === oh, "done_onehot", req_done, oh);
        end else
          chk(req_done === '0, "no_done", req_done, '0);
        chk(req_data === exp_data, "req_data", req_data, exp_data);
      end
      p_lv = l2_valid; p_la = l2_addr; p_done = req_done; p_data = req_data;
    end
  end

  task automatic raise(input int i);
    logic [31:0] a;
    a = $urandom;
    a[3:0] = 4'(i);
    req_valid[i] = 1'b1;
    req_addr[i]  = a;
  endtask

  // One cycle of stimulus, driven on the falling edge.
  task automatic step();
    bit rp;
    @(negedge clk);
    rp = rdy;
    if (l2_auto) begin
      if (l2_done) begin
        if (rp) l2_done = 1'b0;
      end else if (!l2_valid) l2_cnt = l2_rand ? int'($urandom_range(0, 3)) : l2_lat;
      else if (l2_cnt == 0) begin
        l2_done = 1'b1;
        l2_data = l2_rand ? $urandom : l2_fix;
      end else l2_cnt--;
    end
    for (int i = 0; i < N; i++) begin
      if (req_done[i]) req_valid[i] = 1'b0;
      else if (req_auto && !req_valid[i] && $urandom_range(0, 3) == 0) raise(i);
      else if (req_auto && req_valid[i] && $urandom_range(0, 59) == 0) req_valid[i] = 1'b0;
      else if (rearm && !req_valid[i]) raise(i);
    end
    if (rdy_auto) rdy = ($urandom_range(0, 9) != 0);
    if (rst_auto) rst_n = ($urandom_range(0, 499) != 0);
  endtask

  task automatic wait_lv(input string nm);
    int k = 0;
    while (l2_valid !== 1'b1 && k < 50) begin step(); k++; end
    chk(l2_valid === 1'b1, nm, l2_valid, 1'b1);
  endtask

  task automatic wait_done(input int i, input string nm);
    int k = 0;
    while (req_done[i] !== 1'b1 && k < 50) begin step(); k++; end
    chk(req_done[i] === 1'b1, nm, req_done, 1 << i);
  endtask

  function automatic int log_code();
    int c = 1;
    foreach (grant_log[i]) c = c * 10 + grant_log[i];
    return c;
  endfunction

  initial begin
    int k;
    rst_n = 1'b0; rdy = 1'b1; l2_done = 1'b0; l2_data = '0;
    req_valid = '0; req_addr = '0;
    repeat (3) step();
    rst_n = 1'b1;

    // Single request from requester 2, L2 answers with a fixed word.
    req_valid[2] = 1'b1; req_addr[2] = 32'h1000;
    wait_lv("single_l2_valid");
    chk(l2_addr === 32'h1000, "single_l2_addr", l2_addr, 32'h1000);
    wait_done(2, "single_done");
    chk(req_data[2] === 32'hDEADBEEF, "single_data", req_data[2], 32'hDEADBEEF);
    repeat (2) step();

    // Pointer now 3: serve 3, then 1+4 together (4 first, wrap), then 0+2 (2 first).
    grant_log.delete();
    raise(3); wait_done(3, "wrap_d3"); repeat (2) step();
    raise(1); raise(4);
    wait_done(4, "wrap_d4"); wait_done(1, "wrap_d1"); repeat (2) step();
    raise(0); raise(2);
    wait_done(2, "wrap_d2"); wait_done(0, "wrap_d0"); repeat (2) step();
    chk(log_code() == 134120, "wrap_order", log_code(), 134120);

    // All five persistently requesting from reset.
    rst_n = 1'b0; req_valid = '0; repeat (2) step();
    rst_n = 1'b1; grant_log.delete(); rearm = 1'b1;
    k = 0;
    while (grant_log.size() < 6 && k < 200) begin step(); k++; end
    rearm = 1'b0; req_valid = '0;
    chk(log_code() == 1012340, "all5_order", log_code(), 1012340);
    repeat (10) step();

    // rdy low for 3 cycles while l2_done is pending in BUSY.
    l2_auto = 1'b0;
    raise(1); wait_lv("rdy_l2_valid");
    l2_done = 1'b1; l2_data = 32'h0BADF00D; rdy = 1'b0;
    repeat (3) step();
    chk(req_done === '0, "rdy_low_nodone", req_done, '0);
    rdy = 1'b1; step();
    chk(req_done[1] === 1'b1 && req_data[1] === 32'h0BADF00D, "rdy_release_done",
        {req_done, req_data[1]}, {5'b00010, 32'h0BADF00D});
    l2_done = 1'b0; repeat (2) step();

    // Reset mid-BUSY, then a late l2_done.
    raise(3); wait_lv("rst_l2_valid");
    rst_n = 1'b0; req_valid = '0; step();
    rst_n = 1'b1; l2_done = 1'b1; l2_data = $urandom; repeat (2) step();
    l2_done = 1'b0;
    chk(l2_valid === 1'b0 && req_done === '0, "rst_late_done", {l2_valid, req_done}, '0);
    l2_auto = 1'b1; grant_log.delete();
    raise(0); raise(4);
    wait_done(0, "rst_ptr0_d0"); wait_done(4, "rst_ptr0_d4"); repeat (2) step();
    chk(log_code() == 104, "rst_ptr_order", log_code(), 104);

    // Randomized traffic with random L2 latency, rdy stalls and occasional resets.
    l2_rand = 1'b1; req_auto = 1'b1; rdy_auto = 1'b1; rst_auto = 1'b1;
    repeat (4000) step();
    req_auto = 1'b0; rdy_auto = 1'b0; rst_auto = 1'b0; rdy = 1'b1; rst_n = 1'b1;
    repeat (100) step();
    chk(req_valid === '0 && l2_valid === 1'b0, "drain", {req_valid, l2_valid}, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
